// File: rtl/mmio_data_bus_pkg.sv
// Shared offsets, STATUS bit positions and region type for the data-side bus.
// Used by mmio_data_bus (optional CYCLE timer: MMIO_DATA_BUS_TIMER_EN).
package mmio_pkg;

    localparam logic [7:0] LED_OFS    = 8'h00;
    localparam logic [7:0] SW_OFS     = 8'h04;
    localparam logic [7:0] TXDATA_OFS = 8'h08;
    localparam logic [7:0] STATUS_OFS = 8'h0C;
    localparam logic [7:0] CYCLE_OFS  = 8'h10;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/mmio_data_bus_tx_fifo.sv
// Registered-head FIFO for the TX byte stream; no push-to-head bypass.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = r_mem[r_rp];
    assign count  = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= push_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_data_bus.sv
// Data-side bus: word RAM plus an I/O page (LED, SW, TX FIFO, STATUS, CYCLE).
// Define MMIO_DATA_BUS_TIMER_EN to build the free-running CYCLE counter.
module mmio_data_bus
    import mmio_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter logic [19:0] IO_PAGE    = 20'h00001,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [9:0]  sw,
    output logic [9:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    r_mem [RAM_WORDS];
    logic [9:0]     r_led;
    logic [9:0]     r_sw_meta;
    logic [9:0]     r_sw_sync;
    logic           r_ovf;

    region_e        w_region;
    logic [RAW-1:0] w_ram_idx;
    logic [5:0]     w_ofs;
    logic           w_io_wr;
    logic           w_sel_led;
    logic           w_sel_sw;
    logic           w_sel_tx;
    logic           w_sel_st;
    logic           w_sel_cyc;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [3:0]     w_cnt_disp;
    logic [31:0]    w_status;
    logic [31:0]    w_cycle;
    logic [31:0]    w_rd;
    logic           w_unused_bits;

    assign w_unused_bits = ^{ALUResult[11:8], ALUResult[1:0]};

    always_comb begin
        w_region = REG_NONE;
        if (ALUResult < 32'(RAM_WORDS * 4)) begin
            w_region = REG_RAM;
        end else if (ALUResult[31:12] == IO_PAGE) begin
            w_region = REG_IO;
        end
    end

    assign w_ram_idx = ALUResult[RAW+1:2];
    assign w_ofs     = ALUResult[7:2];
    assign w_io_wr   = MemWrite && (w_region == REG_IO);
    assign w_sel_led = (w_ofs == LED_OFS[7:2]);
    assign w_sel_sw  = (w_ofs == SW_OFS[7:2]);
    assign w_sel_tx  = (w_ofs == TXDATA_OFS[7:2]);
    assign w_sel_st  = (w_ofs == STATUS_OFS[7:2]);
    assign w_sel_cyc = (w_ofs == CYCLE_OFS[7:2]);

    always_ff @(posedge clk) begin
        if (MemWrite && (w_region == REG_RAM)) begin
            r_mem[w_ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_io_wr && w_sel_led) begin
                r_led <= WriteData[9:0];
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_io_wr && w_sel_st && WriteData[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef MMIO_DATA_BUS_TIMER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_io_wr && w_sel_cyc) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    assign w_push = w_io_wr && w_sel_tx;
    assign w_pop  = tx_valid && tx_ready;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (WriteData[7:0]),
        .pop       (w_pop),
        .head      (tx_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign tx_valid = !w_empty;
    assign led      = r_led;

    always_comb begin
        w_cnt_disp = 4'(w_count);
        if (32'(w_count) > 32'd15) begin
            w_cnt_disp = 4'hF;
        end
    end

    always_comb begin
        w_status                            = '0;
        w_status[ST_FULL]                   = w_full;
        w_status[ST_EMPTY]                  = w_empty;
        w_status[ST_OVF]                    = r_ovf;
        w_status[ST_CNT_LSB+3:ST_CNT_LSB]   = w_cnt_disp;
    end

    always_comb begin
        w_rd = '0;
        case (w_region)
            REG_RAM: w_rd = r_mem[w_ram_idx];
            REG_IO: begin
                if (w_sel_led)      w_rd = {22'b0, r_led};
                else if (w_sel_sw)  w_rd = {22'b0, r_sw_sync};
                else if (w_sel_st)  w_rd = w_status;
                else if (w_sel_cyc) w_rd = w_cycle;
            end
            default: w_rd = '0;
        endcase
    end

    assign ReadData = w_rd;

endmodule
